mod12_load_arbiter: RTL

MOD12_LOAD_ARBITER -- requirements
Module: mod12_load_arbiter

---
 rtl/mod12_load_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/mod12_load_arbiter.sv
// mod12_load_arbiter: modulo-MODULUS counter with a two-state run/idle FSM
// and a round-robin arbiter that lets two requesters load the count.
// A granted value outside 0..MODULUS-1 is not loaded. Instead it raises err.
module mod12_load_arbiter #(
  parameter int MODULUS = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] req,
  input  logic [3:0] load_val0,
  input  logic [3:0] load_val1,
  output logic [1:0] gnt,
  output logic       err,
  output logic [3:0] count,
  output logic       wrap,
  output logic       running
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [4:0] MOD_EXT = 5'(MODULUS);
  localparam logic [3:0] CNT_MAX = 4'(MODULUS - 1);

  state_t     state_q;
  logic       ptr_q;      // 1: requester 1 wins a tie, 0: requester 0 wins
  logic [3:0] count_q, count_d;
  logic [1:0] gnt_q, gnt_d;
  logic       err_q, err_d;
  logic       wrap_q, wrap_d;
  logic       ptr_d;

  logic       any_req;
  logic       win_sel;    // index of the winning requester
  logic [3:0] sel_val;
  logic       in_range;

  // Arbitration and next-count decode for the coming edge
  always_comb begin
    any_req  = |req;
    win_sel  = (req == 2'b10) || ((req == 2'b11) && ptr_q);
    sel_val  = win_sel ? load_val1 : load_val0;
    in_range = ({1'b0, sel_val} < MOD_EXT);

    gnt_d   = 2'b00;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    ptr_d   = ptr_q;
    count_d = count_q;

    if (any_req) begin
      gnt_d = win_sel ? 2'b10 : 2'b01;
      err_d = ~in_range;
      // After a grant the tie goes to the other requester
      ptr_d = ~win_sel;
    end

    if (any_req && in_range) begin
      count_d = sel_val;
    end else if (state_q == RUN) begin
      if (count_q == CNT_MAX) begin
        count_d = 4'd0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + 4'd1;
      end
    end
  end

  // State, pointer and registered outputs; reset clears everything at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      count_q <= 4'd0;
      gnt_q   <= 2'b00;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start && !stop) state_q <= RUN;
        RUN:  if (stop)           state_q <= IDLE;
        default:                  state_q <= IDLE;
      endcase
      ptr_q   <= ptr_d;
      count_q <= count_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
    end
  end

  assign gnt     = gnt_q;
  assign err     = err_q;
  assign count   = count_q;
  assign wrap    = wrap_q;
  assign running = (state_q == RUN);

endmodule
